// File: rtl/stopwatch_pkg.sv
// Shared widths, default wrap limits, mode encoding and a BCD helper for the stopwatch.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package stopwatch_pkg;

    localparam int BCD_W       = 4;
    localparam int SEC_LIMIT_D = 59;
    localparam int MIN_LIMIT_D = 59;

    typedef enum logic {
        MODE_RUN = 1'b0,
        MODE_ADJ = 1'b1
    } mode_t;

    // Two-digit packed BCD {tens,ones} of a 0..99 integer.
    function automatic logic [2*BCD_W-1:0] to_bcd(input int val);
        to_bcd = {BCD_W'(val / 10), BCD_W'(val % 10)};
    endfunction

endpackage

// File: rtl/bcd_field_counter.sv
// Two-digit BCD counter that wraps to 00 after reaching limit.
// Latency: new value one cycle after inc; wrap is combinational (inc && value == limit).
// Backpressure: none, every inc is taken.
module bcd_field_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               inc,
    input  logic [2*BCD_W-1:0] limit,
    output logic [BCD_W-1:0]   tens,
    output logic [BCD_W-1:0]   ones,
    output logic               wrap
);

    logic at_limit;

    assign at_limit = ({tens, ones} == limit);
    assign wrap     = inc && at_limit;

    always_ff @(posedge clk) begin
        if (rst) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (at_limit) begin
                tens <= '0;
                ones <= '0;
            end else if (ones == BCD_W'(9)) begin
                ones <= '0;
                tens <= tens + BCD_W'(1);
            end else begin
                ones <= ones + BCD_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_core.sv
// MM:SS BCD stopwatch: counts on the 1 Hz strobe, steps the selected field on the 2 Hz strobe in adjust mode.
// Latency: a qualifying strobe in cycle N shows on the registered outputs in cycle N+1.
// Backpressure: none; strobes are consumed as they arrive, non-qualifying ones are dropped.
module stopwatch_core
    import stopwatch_pkg::*;
#(
    parameter int MIN_LIMIT = MIN_LIMIT_D,
    parameter int SEC_LIMIT = SEC_LIMIT_D
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             one_hz_tick,
    input  logic             two_hz_tick,
    input  logic             pause_pulse,
    input  logic             adj,
    input  logic             sel,
    output logic [BCD_W-1:0] min_tens,
    output logic [BCD_W-1:0] min_ones,
    output logic [BCD_W-1:0] sec_tens,
    output logic [BCD_W-1:0] sec_ones,
    output logic             paused,
    output logic             rollover
);

    localparam logic [2*BCD_W-1:0] SEC_LIM_BCD = to_bcd(SEC_LIMIT);
    localparam logic [2*BCD_W-1:0] MIN_LIM_BCD = to_bcd(MIN_LIMIT);

    mode_t mode;
    logic  sec_inc;
    logic  min_inc;
    logic  sec_wrap;
    logic  min_wrap;

    assign mode = mode_t'(adj);

    // The tick sees the pre-toggle paused value, so a coincident pause press still lets it count.
    always_comb begin
        sec_inc = 1'b0;
        min_inc = 1'b0;
        case (mode)
            MODE_RUN: begin
                sec_inc = one_hz_tick && !paused;
                min_inc = sec_wrap;
            end
            MODE_ADJ: begin
                sec_inc = two_hz_tick && sel;
                min_inc = two_hz_tick && !sel;
            end
            default: ;
        endcase
    end

    bcd_field_counter u_sec (
        .clk   (clk),
        .rst   (rst),
        .inc   (sec_inc),
        .limit (SEC_LIM_BCD),
        .tens  (sec_tens),
        .ones  (sec_ones),
        .wrap  (sec_wrap)
    );

    bcd_field_counter u_min (
        .clk   (clk),
        .rst   (rst),
        .inc   (min_inc),
        .limit (MIN_LIM_BCD),
        .tens  (min_tens),
        .ones  (min_ones),
        .wrap  (min_wrap)
    );

    // A minutes wrap while adjusting is a manual edit, not an elapsed-hour event.
    always_ff @(posedge clk) begin
        if (rst) begin
            paused   <= 1'b0;
            rollover <= 1'b0;
        end else begin
            if (pause_pulse)
                paused <= ~paused;
            rollover <= (mode == MODE_RUN) && min_wrap;
        end
    end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed scoreboard bench for stopwatch_core: stimulus queues hand-computed expectations,
// a monitor compares them one cycle after the driving edge.
module tb_stopwatch_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       one_hz_tick = 1'b0;
    logic       two_hz_tick = 1'b0;
    logic       pause_pulse = 1'b0;
    logic       adj = 1'b0;
    logic       sel = 1'b0;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       paused, rollover;

    logic cur_adj = 1'b0;
    logic cur_sel = 1'b0;

    int checks = 0;
    int errors = 0;
    int cycn   = 0;

    typedef struct {
        int          due;
        logic        cd;
        logic [15:0] dig;
        logic        p;
        logic        ro;
    } exp_t;

    exp_t q[$];

    always #5 clk = ~clk;

    stopwatch_core dut (
        .clk         (clk),
        .rst         (rst),
        .one_hz_tick (one_hz_tick),
        .two_hz_tick (two_hz_tick),
        .pause_pulse (pause_pulse),
        .adj         (adj),
        .sel         (sel),
        .min_tens    (min_tens),
        .min_ones    (min_ones),
        .sec_tens    (sec_tens),
        .sec_ones    (sec_ones),
        .paused      (paused),
        .rollover    (rollover)
    );

    // Drive one cycle of inputs at the falling edge; the result is due after the next rising edge.
    task automatic cyc(input logic t1, input logic t2, input logic pp, input logic r,
                       input logic cd, input logic [15:0] d, input logic p, input logic ro);
        exp_t e;
        @(negedge clk);
        one_hz_tick = t1;
        two_hz_tick = t2;
        pause_pulse = pp;
        rst         = r;
        adj         = cur_adj;
        sel         = cur_sel;
        e.due = cycn + 1;
        e.cd  = cd;
        e.dig = d;
        e.p   = p;
        e.ro  = ro;
        q.push_back(e);
    endtask

    task automatic idle(input logic p);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, p, 1'b0);
    endtask

    always @(posedge clk) begin
        #1;
        cycn++;
        while (q.size() > 0 && q[0].due == cycn) begin
            exp_t e;
            logic [15:0] got;
            e   = q.pop_front();
            got = {min_tens, min_ones, sec_tens, sec_ones};
            if (e.cd) begin
                checks++;
                if (got !== e.dig) begin
                    errors++;
                    $display("FAIL digits cycle %0d: got %h required %h", cycn, got, e.dig);
                end
            end
            checks++;
            if (paused !== e.p) begin
                errors++;
                $display("FAIL paused cycle %0d: got %b required %b", cycn, paused, e.p);
            end
            checks++;
            if (rollover !== e.ro) begin
                errors++;
                $display("FAIL rollover cycle %0d: got %b required %b", cycn, rollover, e.ro);
            end
        end
    end

    initial begin
        // Reset state
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);

        // 75 seconds of running: 01:15, rollover never high
        for (int i = 1; i <= 75; i++) begin
            logic        cd;
            logic [15:0] d;
            cd = 1'b1;
            case (i)
                10:      d = 16'h0010;
                59:      d = 16'h0059;
                60:      d = 16'h0100;
                75:      d = 16'h0115;
                default: begin cd = 1'b0; d = 16'h0000; end
            endcase
            cyc(1'b1, 1'b0, 1'b0, 1'b0, cd, d, 1'b0, 1'b0);
            idle(1'b0);
        end

        // Preload 59:58 through adjust mode
        cur_adj = 1'b1;
        cur_sel = 1'b0;
        for (int i = 0; i < 58; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i == 57), 16'h5915, 1'b0, 1'b0);
        cur_sel = 1'b1;
        for (int i = 0; i < 43; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i == 42), 16'h5958, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5958, 1'b0, 1'b0);

        // Run across the hour boundary: single-cycle rollover
        cur_adj = 1'b0;
        cur_sel = 1'b0;
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5959, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h5959, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);

        // Paused: ticks have no effect
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++)
            cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        idle(1'b1);

        // Pause press coincident with a tick, both directions
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Seconds to 00:58 via adjust
        cur_adj = 1'b1;
        cur_sel = 1'b1;
        for (int i = 0; i < 57; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i == 56), 16'h0058, 1'b0, 1'b0);

        // Seconds wrap in adjust: no carry, no rollover, 1 Hz ignored, sel change alone inert
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0059, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0059, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cur_sel = 1'b0;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0);
        cur_sel = 1'b1;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);

        // Build 58:30, then minutes wrap in adjust without rollover
        cur_sel = 1'b0;
        for (int i = 0; i < 58; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i == 57), 16'h5801, 1'b0, 1'b0);
        cur_sel = 1'b1;
        for (int i = 0; i < 29; i++)
            cyc(1'b0, 1'b1, 1'b0, 1'b0, (i == 28), 16'h5830, 1'b0, 1'b0);
        cur_sel = 1'b0;
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h5930, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'h0030, 1'b0, 1'b0);

        // Pause, then reset with strobes in the same cycle: 00:00 running
        cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0030, 1'b1, 1'b0);
        cur_adj = 1'b0;
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0);
        idle(1'b0);

        // Drain the scoreboard within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++)
            @(negedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
